// File: rtl/rst_seq_pkg.sv
// Shared definitions for the reset sequencer: FSM state encoding and the
// width of the clock-enable divider counter.
package rst_seq_pkg;

    // Sequencer phases: all domains held, staged release, normal operation.
    typedef enum logic [1:0] {
        ST_ASSERT  = 2'd0,
        ST_RELEASE = 2'd1,
        ST_RUN     = 2'd2
    } seq_state_e;

    // The enable counter spans /2 through /16, so four bits cover every strobe.
    localparam int CE_CNT_W = 4;

endpackage

// File: rtl/rst_seq_ctrl_ce_gen.sv
// Clock-enable strobe generator for rst_seq_ctrl.
// A free-running counter advances only while the sequencer is in RUN.
// Strobe k fires when the low k+1 counter bits are all ones.
// A clear input zeroes the counter so that every RUN period starts phase-aligned
// from 0.
module ce_gen
    import rst_seq_pkg::*;
(
    input  logic clk,
    input  logic run,
    input  logic clear,
    output logic ce_div2,
    output logic ce_div4,
    output logic ce_div8,
    output logic ce_div16
);

    logic [CE_CNT_W-1:0] cnt_q;
    logic [CE_CNT_W-1:0] cnt_d;
    logic [CE_CNT_W-1:0] ce_vec;

    // Next count: clear wins, otherwise advance only in RUN (wraps naturally).
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (run) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        cnt_q <= cnt_d;
    end

    // Strobe gi is high when the low gi+1 bits are all ones, gated by RUN.
    generate
        for (genvar gi = 0; gi < CE_CNT_W; gi++) begin : g_strobe
            assign ce_vec[gi] = run & (&cnt_q[gi:0]);
        end
    endgenerate

    assign ce_div2  = ce_vec[0];
    assign ce_div4  = ce_vec[1];
    assign ce_div8  = ce_vec[2];
    assign ce_div16 = ce_vec[3];

endmodule

// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: holds all domain resets for HOLD_CYC cycles, then releases
// them one by one, lowest index first, every STAGE_CYC cycles. It then sits in
// RUN until a soft-reset request arrives.
// A soft request is level-based. It is accepted once per assertion: after
// acceptance the request line must be seen low before it can trigger again.
// The sequence that a soft request starts ends with a one-cycle soft_ack.
// Optional feature macro RST_SEQ_CE_EN: when defined, a ce_gen instance
// produces divided clock-enable strobes during RUN. When undefined, all ce
// outputs are tied low.
module rst_seq_ctrl
    import rst_seq_pkg::*;
#(
    parameter int NUM_DOM   = 4,
    parameter int HOLD_CYC  = 8,
    parameter int STAGE_CYC = 4
)(
    input  logic               sys_clk,
    input  logic               rst,
    input  logic               soft_req,
    output logic               soft_ack,
    output logic [NUM_DOM-1:0] dom_rst,
    output logic               all_ready,
    output logic               seq_busy,
    output logic               ce_div2,
    output logic               ce_div4,
    output logic               ce_div8,
    output logic               ce_div16
);

    // One timer serves both the hold phase and each release stage.
    localparam int MAX_CYC = (HOLD_CYC > STAGE_CYC) ? HOLD_CYC : STAGE_CYC;
    localparam int TMR_W   = $clog2(MAX_CYC) + 1;
    localparam int IDX_W   = (NUM_DOM > 1) ? $clog2(NUM_DOM) : 1;

    localparam logic [TMR_W-1:0] HOLD_LAST  = TMR_W'(HOLD_CYC - 1);
    localparam logic [TMR_W-1:0] STAGE_LAST = TMR_W'(STAGE_CYC - 1);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_DOM - 1);

    seq_state_e         state_q, state_d;
    logic [TMR_W-1:0]   tmr_q, tmr_d;
    logic [IDX_W-1:0]   idx_q, idx_d;       // next domain to be released
    logic [NUM_DOM-1:0] dom_q, dom_d;
    logic               armed_q, armed_d;   // soft request may be accepted
    logic               pend_q, pend_d;     // current sequence was soft-triggered
    logic               ack_q, ack_d;

    // Sequencing FSM: the hold timer, the staged release and soft-request acceptance.
    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        idx_d   = idx_q;
        dom_d   = dom_q;
        armed_d = armed_q;
        pend_d  = pend_q;
        ack_d   = 1'b0;

        // Seeing the request low re-arms; acceptance below disarms.
        if (!soft_req) begin
            armed_d = 1'b1;
        end

        case (state_q)
            ST_ASSERT: begin
                dom_d = '1;
                if (tmr_q == HOLD_LAST) begin
                    // Domain 0 is released at the end of the hold phase.
                    tmr_d    = '0;
                    dom_d[0] = 1'b0;
                    idx_d    = IDX_W'(1);
                    if (NUM_DOM == 1) begin
                        state_d = ST_RUN;
                        ack_d   = pend_q;
                        pend_d  = 1'b0;
                    end else begin
                        state_d = ST_RELEASE;
                    end
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end

            ST_RELEASE: begin
                if (tmr_q == STAGE_LAST) begin
                    tmr_d        = '0;
                    dom_d[idx_q] = 1'b0;
                    idx_d        = idx_q + 1'b1;
                    if (idx_q == LAST_IDX) begin
                        // Last domain falls together with entry to RUN.
                        state_d = ST_RUN;
                        ack_d   = pend_q;
                        pend_d  = 1'b0;
                    end
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end

            ST_RUN: begin
                if (soft_req && armed_q) begin
                    state_d = ST_ASSERT;
                    dom_d   = '1;
                    tmr_d   = '0;
                    idx_d   = '0;
                    armed_d = 1'b0;
                    pend_d  = 1'b1;
                end
            end

            default: begin
                state_d = ST_ASSERT;
                dom_d   = '1;
                tmr_d   = '0;
                idx_d   = '0;
            end
        endcase
    end

    // State registers; reset restarts the sequence and drops any pending acknowledge.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_q <= ST_ASSERT;
            tmr_q   <= '0;
            idx_q   <= '0;
            dom_q   <= '1;
            armed_q <= 1'b1;
            pend_q  <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            idx_q   <= idx_d;
            dom_q   <= dom_d;
            armed_q <= armed_d;
            pend_q  <= pend_d;
            ack_q   <= ack_d;
        end
    end

    assign dom_rst   = dom_q;
    assign soft_ack  = ack_q;
    assign all_ready = (state_q == ST_RUN);
    assign seq_busy  = (state_q == ST_ASSERT) || (state_q == ST_RELEASE);

`ifdef RST_SEQ_CE_EN
    logic run_w;
    logic clear_w;

    // Clear at the same edge that leaves RUN, so the counter re-enters at 0.
    assign run_w   = (state_q == ST_RUN);
    assign clear_w = rst || (state_d != ST_RUN);

    ce_gen u_ce_gen (
        .clk      (sys_clk),
        .run      (run_w),
        .clear    (clear_w),
        .ce_div2  (ce_div2),
        .ce_div4  (ce_div4),
        .ce_div8  (ce_div8),
        .ce_div16 (ce_div16)
    );
`else
    assign ce_div2  = 1'b0;
    assign ce_div4  = 1'b0;
    assign ce_div8  = 1'b0;
    assign ce_div16 = 1'b0;
`endif

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Directed bench for rst_seq_ctrl (NUM_DOM=4, HOLD_CYC=8, STAGE_CYC=4).
// Cycle s counts from the first cycle in which rst is sampled low, or from the
// first cycle after a soft request is accepted. Expected outputs come from the
// hand-written release table {8,12,16,20}. RUN starts at s=20. Strobes follow
// the RUN cycle count n=s-20 when RST_SEQ_CE_EN is defined and are zero
// otherwise.
module tb_rst_seq_ctrl;

    logic       sys_clk = 1'b0;
    logic       rst = 1'b1;
    logic       soft_req = 1'b0;
    logic       soft_ack;
    logic [3:0] dom_rst;
    logic       all_ready;
    logic       seq_busy;
    logic       ce_div2, ce_div4, ce_div8, ce_div16;
    logic [10:0] obs;

    int checks = 0;
    int errors = 0;
    int rel_cyc [4] = '{8, 12, 16, 20};

    always #5 sys_clk = ~sys_clk;

    rst_seq_ctrl #(
        .NUM_DOM   (4),
        .HOLD_CYC  (8),
        .STAGE_CYC (4)
    ) dut (
        .sys_clk   (sys_clk),
        .rst       (rst),
        .soft_req  (soft_req),
        .soft_ack  (soft_ack),
        .dom_rst   (dom_rst),
        .all_ready (all_ready),
        .seq_busy  (seq_busy),
        .ce_div2   (ce_div2),
        .ce_div4   (ce_div4),
        .ce_div8   (ce_div8),
        .ce_div16  (ce_div16)
    );

    assign obs = {dom_rst, all_ready, seq_busy, soft_ack, ce_div16, ce_div8, ce_div4, ce_div2};

    // Expected {dom_rst, all_ready, seq_busy, soft_ack, ce16, ce8, ce4, ce2} at cycle s.
    function automatic logic [10:0] exp_vec(int s, bit soft_seq);
        logic [3:0] d;
        logic [3:0] ce;
        logic       rdy, busy, ack;
        ce = '0;
        for (int i = 0; i < 4; i++) d[i] = (s < rel_cyc[i]);
        rdy  = (s >= 20);
        busy = (s < 20);
        ack  = soft_seq && (s == 20);
`ifdef RST_SEQ_CE_EN
        if (s >= 20) begin
            ce[0] = ((s - 20) % 2 == 1);
            ce[1] = ((s - 20) % 4 == 3);
            ce[2] = ((s - 20) % 8 == 7);
            ce[3] = ((s - 20) % 16 == 15);
        end
`endif
        return {d, rdy, busy, ack, ce[3], ce[2], ce[1], ce[0]};
    endfunction

    task automatic next_cycle();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic test_reset();
        next_cycle();
        for (int k = 0; k < 3; k++) begin
            @(negedge sys_clk);
            checks++;
            if (obs !== 11'b1111_010_0000) begin
                errors++;
                $display("FAIL reset k=%0d got=%b exp=%b", k, obs, 11'b1111_010_0000);
            end
            next_cycle();
        end
    endtask

    // Release from rst; checks the release timeline plus strobes up to n=35 (ce_div16 at 35 and 51).
    task automatic test_power_up();
        rst = 1'b0;
        for (int s = 0; s <= 55; s++) begin
            @(negedge sys_clk);
            checks++;
            if (obs !== exp_vec(s, 1'b0)) begin
                errors++;
                $display("FAIL power_up cyc=%0d got=%b exp=%b", s, obs, exp_vec(s, 1'b0));
            end
            next_cycle();
        end
    endtask

    // Held soft request: one sequence, one ack, no retrigger until the line drops.
    task automatic test_soft();
        soft_req = 1'b1;
        @(negedge sys_clk);
        checks++;
        if (obs !== exp_vec(56, 1'b0)) begin
            errors++;
            $display("FAIL soft_accept_cycle got=%b exp=%b", obs, exp_vec(56, 1'b0));
        end
        next_cycle();
        for (int s = 0; s <= 46; s++) begin
            soft_req = (s != 45);
            @(negedge sys_clk);
            checks++;
            if (obs !== exp_vec(s, 1'b1)) begin
                errors++;
                $display("FAIL soft_held cyc=%0d got=%b exp=%b", s, obs, exp_vec(s, 1'b1));
            end
            next_cycle();
        end
        // Request re-raised after one low cycle: a fresh sequence must start.
        soft_req = 1'b0;
        for (int s = 0; s <= 21; s++) begin
            @(negedge sys_clk);
            checks++;
            if (obs !== exp_vec(s, 1'b1)) begin
                errors++;
                $display("FAIL soft_retrigger cyc=%0d got=%b exp=%b", s, obs, exp_vec(s, 1'b1));
            end
            next_cycle();
        end
    endtask

    // Soft request during RELEASE must be ignored.
    task automatic test_soft_during_release();
        rst = 1'b1;
        @(negedge sys_clk);
        checks++;
        if (obs !== exp_vec(22, 1'b1)) begin
            errors++;
            $display("FAIL pre_rst_cycle got=%b exp=%b", obs, exp_vec(22, 1'b1));
        end
        next_cycle();
        rst = 1'b0;
        for (int s = 0; s <= 30; s++) begin
            soft_req = (s >= 10) && (s < 13);
            @(negedge sys_clk);
            checks++;
            if (obs !== exp_vec(s, 1'b0)) begin
                errors++;
                $display("FAIL soft_in_release cyc=%0d got=%b exp=%b", s, obs, exp_vec(s, 1'b0));
            end
            next_cycle();
        end
        soft_req = 1'b0;
    endtask

    // rst at cycle 14 of a soft sequence: restart from 0 and never acknowledge.
    task automatic test_rst_mid_soft();
        soft_req = 1'b1;
        @(negedge sys_clk);
        checks++;
        if (obs !== exp_vec(31, 1'b0)) begin
            errors++;
            $display("FAIL mid_soft_accept got=%b exp=%b", obs, exp_vec(31, 1'b0));
        end
        next_cycle();
        soft_req = 1'b0;
        for (int s = 0; s <= 14; s++) begin
            rst = (s == 14);
            @(negedge sys_clk);
            checks++;
            if (obs !== exp_vec(s, 1'b1)) begin
                errors++;
                $display("FAIL mid_soft_pre cyc=%0d got=%b exp=%b", s, obs, exp_vec(s, 1'b1));
            end
            next_cycle();
        end
        rst = 1'b0;
        for (int s = 0; s <= 24; s++) begin
            @(negedge sys_clk);
            checks++;
            if (obs !== exp_vec(s, 1'b0)) begin
                errors++;
                $display("FAIL mid_soft_restart cyc=%0d got=%b exp=%b", s, obs, exp_vec(s, 1'b0));
            end
            next_cycle();
        end
    endtask

    initial begin
        test_reset();
        test_power_up();
        test_soft();
        test_soft_during_release();
        test_rst_mid_soft();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
